// File: rtl/cpu_alu_decode_pkg.sv
// -----------------------------------------------------------------------------
// cpu_alu_decode_pkg
// Shared definitions for the CPU ALU / instruction-field decoder slice.
//   - alu_op_e  : 3-bit ALU operation codes (ALU_OP_NOP .. ALU_OP_SBC)
//   - reg_idx_e : 3-bit "r" register index table (REG_B .. REG_A, 6 = (HL))
//   - opcode field values used by the class detector
// -----------------------------------------------------------------------------
package cpu_alu_decode_pkg;

    typedef enum logic [2:0] {
        ALU_OP_NOP = 3'b000,
        ALU_OP_ADD = 3'b001,
        ALU_OP_SUB = 3'b010,
        ALU_OP_AND = 3'b011,
        ALU_OP_OR  = 3'b100,
        ALU_OP_XOR = 3'b101,
        ALU_OP_ADC = 3'b110,
        ALU_OP_SBC = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        REG_B      = 3'd0,
        REG_C      = 3'd1,
        REG_D      = 3'd2,
        REG_E      = 3'd3,
        REG_H      = 3'd4,
        REG_L      = 3'd5,
        REG_HL_MEM = 3'd6,   // (HL): memory operand addressed by HL
        REG_A      = 3'd7
    } reg_idx_e;

    // Field values that identify the decoded instruction classes.
    localparam logic [1:0] X_BLOCK0 = 2'd0;
    localparam logic [1:0] X_BLOCK3 = 2'd3;
    localparam logic [2:0] Z_INC_R  = 3'd4;
    localparam logic [2:0] Z_LD_R_N = 3'd6;
    localparam logic [2:0] Z_JP     = 3'd3;

endpackage

// File: rtl/cpu_alu_decode_if.sv
// -----------------------------------------------------------------------------
// cpu_alu_decode_if
// Bundle between the CPU state machine (master) and the ALU/decoder (slave).
//   master drives : insn, operand_a, operand_b, operator
//   slave drives  : insn_x/y/z/p/q, is_nop, is_inc_r, is_ld_r_n, is_jp_nn,
//                   result, res_zero, res_carry, flag_zero, flag_carry
// -----------------------------------------------------------------------------
interface cpu_alu_decode_if;

    logic [7:0] insn;
    logic [1:0] insn_x;
    logic [2:0] insn_y;
    logic [2:0] insn_z;
    logic [1:0] insn_p;
    logic       insn_q;
    logic       is_nop;
    logic       is_inc_r;
    logic       is_ld_r_n;
    logic       is_jp_nn;

    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [2:0] operator;
    logic [7:0] result;
    logic       res_zero;
    logic       res_carry;
    logic       flag_zero;
    logic       flag_carry;

    modport master (
        output insn, operand_a, operand_b, operator,
        input  insn_x, insn_y, insn_z, insn_p, insn_q,
               is_nop, is_inc_r, is_ld_r_n, is_jp_nn,
               result, res_zero, res_carry, flag_zero, flag_carry
    );

    modport slave (
        input  insn, operand_a, operand_b, operator,
        output insn_x, insn_y, insn_z, insn_p, insn_q,
               is_nop, is_inc_r, is_ld_r_n, is_jp_nn,
               result, res_zero, res_carry, flag_zero, flag_carry
    );

endinterface

// File: rtl/cpu_alu_decode_insn_fields.sv
// -----------------------------------------------------------------------------
// cpu_insn_fields
// Combinational opcode field slicer and instruction-class detector.
//   i_insn      : opcode byte
//   o_x/y/z/p/q : standard x[7:6] y[5:3] z[2:0] p[5:4] q[3] fields
//   o_is_*      : class flags; the classes are disjoint so at most one is high
// -----------------------------------------------------------------------------
module cpu_insn_fields
    import cpu_alu_decode_pkg::*;
(
    input  logic [7:0] i_insn,
    output logic [1:0] o_x,
    output logic [2:0] o_y,
    output logic [2:0] o_z,
    output logic [1:0] o_p,
    output logic       o_q,
    output logic       o_is_nop,
    output logic       o_is_inc_r,
    output logic       o_is_ld_r_n,
    output logic       o_is_jp_nn
);

    assign o_x = i_insn[7:6];
    assign o_y = i_insn[5:3];
    assign o_z = i_insn[2:0];
    assign o_p = i_insn[5:4];
    assign o_q = i_insn[3];

    // NOP and JP nn also pin y, so they cannot overlap the z-only classes.
    assign o_is_nop    = (o_x == X_BLOCK0) && (o_z == 3'd0) && (o_y == 3'd0);
    assign o_is_inc_r  = (o_x == X_BLOCK0) && (o_z == Z_INC_R);
    assign o_is_ld_r_n = (o_x == X_BLOCK0) && (o_z == Z_LD_R_N);
    assign o_is_jp_nn  = (o_x == X_BLOCK3) && (o_z == Z_JP) && (o_y == 3'd0);

endmodule

// File: rtl/cpu_alu_decode.sv
// -----------------------------------------------------------------------------
// cpu_alu_decode
// Instruction-field decoder plus 8-bit ALU with registered zero/carry flags.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears flag_zero / flag_carry only)
//   bus : cpu_alu_decode_if.slave -- opcode/operands in, decode/ALU results out
// Build option:
//   CPU_ALU_CARRY_IN_EN defined   : codes 110/111 are ADC/SBC using flag_carry
//   CPU_ALU_CARRY_IN_EN undefined : codes 110/111 behave as ADD/SUB
// -----------------------------------------------------------------------------
module cpu_alu_decode
    import cpu_alu_decode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cpu_alu_decode_if.slave  bus
);

    // ---------------- decoder ----------------
    logic [1:0] w_x;
    logic [2:0] w_y;
    logic [2:0] w_z;
    logic [1:0] w_p;
    logic       w_q;
    logic       w_is_nop;
    logic       w_is_inc_r;
    logic       w_is_ld_r_n;
    logic       w_is_jp_nn;

    cpu_insn_fields u_fields (
        .i_insn      (bus.insn),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_z         (w_z),
        .o_p         (w_p),
        .o_q         (w_q),
        .o_is_nop    (w_is_nop),
        .o_is_inc_r  (w_is_inc_r),
        .o_is_ld_r_n (w_is_ld_r_n),
        .o_is_jp_nn  (w_is_jp_nn)
    );

    assign bus.insn_x    = w_x;
    assign bus.insn_y    = w_y;
    assign bus.insn_z    = w_z;
    assign bus.insn_p    = w_p;
    assign bus.insn_q    = w_q;
    assign bus.is_nop    = w_is_nop;
    assign bus.is_inc_r  = w_is_inc_r;
    assign bus.is_ld_r_n = w_is_ld_r_n;
    assign bus.is_jp_nn  = w_is_jp_nn;

    // ---------------- ALU ----------------
    alu_op_e    w_op;
    logic       w_cin;
    logic [8:0] w_wide;
    logic       r_flag_zero;
    logic       r_flag_carry;

    assign w_op = alu_op_e'(bus.operator);

`ifdef CPU_ALU_CARRY_IN_EN
    assign w_cin = r_flag_carry;   // flag value from before this edge
`else
    assign w_cin = 1'b0;           // 110/111 collapse onto ADD/SUB
`endif

    // All arithmetic is 9 bits wide: bit 8 is the carry for additions and the
    // borrow for subtractions (a negative difference wraps with bit 8 set).
    // Logic ops and NOP keep bit 8 clear, so it doubles as res_carry for all.
    always_comb begin
        // NOTE: default first so no case path leaves w_wide unassigned (no latch).
        w_wide = '0;
        case (w_op)
            ALU_OP_NOP: w_wide = {1'b0, bus.operand_a};
            ALU_OP_ADD: w_wide = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
            ALU_OP_SUB: w_wide = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
            ALU_OP_AND: w_wide = {1'b0, bus.operand_a & bus.operand_b};
            ALU_OP_OR:  w_wide = {1'b0, bus.operand_a | bus.operand_b};
            ALU_OP_XOR: w_wide = {1'b0, bus.operand_a ^ bus.operand_b};
            ALU_OP_ADC: w_wide = {1'b0, bus.operand_a} + {1'b0, bus.operand_b}
                               + {8'd0, w_cin};
            ALU_OP_SBC: w_wide = {1'b0, bus.operand_a} - {1'b0, bus.operand_b}
                               - {8'd0, w_cin};
            default:    w_wide = '0;
        endcase
    end

    assign bus.result    = w_wide[7:0];
    assign bus.res_zero  = (w_wide[7:0] == 8'h00);
    assign bus.res_carry = w_wide[8];

    // ---------------- flag register ----------------
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
        end else if (w_op != ALU_OP_NOP) begin
            r_flag_zero  <= bus.res_zero;
            r_flag_carry <= bus.res_carry;
        end
    end

    assign bus.flag_zero  = r_flag_zero;
    assign bus.flag_carry = r_flag_carry;

endmodule

// File: tb/tb_cpu_alu_decode.sv
// -----------------------------------------------------------------------------
// tb_cpu_alu_decode
// Self-checking bench for cpu_alu_decode: directed decode/ALU/flag steps
// followed by random ALU traffic compared against an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_cpu_alu_decode;

`ifdef CPU_ALU_CARRY_IN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_alu_decode_if bus ();

    cpu_alu_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit m_fz;
    bit m_fc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: plain integer arithmetic, carry = result out of 0..255.
    function automatic void ref_alu(input int op, input int a, input int b, input bit c,
                                    output int res, output bit cy);
        int t;
        int ci;
        ci = (CIN_EN && c) ? 1 : 0;
        cy = 1'b0;
        t  = 0;
        case (op)
            0: t = a;
            1: begin t = a + b;      cy = (t > 255); end
            2: begin t = a - b;      cy = (t < 0);   end
            3: t = a & b;
            4: t = a | b;
            5: t = a ^ b;
            6: begin t = a + b + ci; cy = (t > 255); end
            7: begin t = a - b - ci; cy = (t < 0);   end
            default: t = 0;
        endcase
        res = t & 255;
    endfunction

    // Present one operation, check the combinational result in the same
    // cycle, clock it, then check the flags one cycle later.
    task automatic alu_step(input string tag, input int op, input int a, input int b);
        int res;
        bit cy;
        bus.operator  = op[2:0];
        bus.operand_a = a[7:0];
        bus.operand_b = b[7:0];
        #1;
        ref_alu(op, a, b, m_fc, res, cy);
        check({tag, ".result"},    bus.result,    res);
        check({tag, ".res_zero"},  bus.res_zero,  (res == 0));
        check({tag, ".res_carry"}, bus.res_carry, cy);
        @(posedge clk);
        if (rst) begin
            m_fz = 1'b0;
            m_fc = 1'b0;
        end else if (op != 0) begin
            m_fz = (res == 0);
            m_fc = cy;
        end
        #1;
        check({tag, ".flag_zero"},  bus.flag_zero,  m_fz);
        check({tag, ".flag_carry"}, bus.flag_carry, m_fc);
    endtask

    // Decode one opcode and compare every field and class flag.
    task automatic decode_check(input int op);
        int x, y, z;
        logic [3:0] cls_exp;
        logic [3:0] cls_obs;
        bus.insn = op[7:0];
        #1;
        x = op / 64;
        y = (op / 8) % 8;
        z = op % 8;
        cls_exp = {(op == 0), (x == 0 && z == 4), (x == 0 && z == 6), (op == 195)};
        cls_obs = {bus.is_nop, bus.is_inc_r, bus.is_ld_r_n, bus.is_jp_nn};
        check($sformatf("dec%02h.fields", op),
              {bus.insn_x, bus.insn_y, bus.insn_z, bus.insn_p, bus.insn_q},
              {x[1:0], y[2:0], z[2:0], y[2:1], y[0]});
        check($sformatf("dec%02h.class", op), cls_obs, cls_exp);
        check($sformatf("dec%02h.onehot0", op), ($countones(cls_obs) <= 1), 1'b1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.insn      = 8'h00;
        bus.operator  = 3'd0;
        bus.operand_a = 8'h00;
        bus.operand_b = 8'h00;
        m_fz          = 1'b0;
        m_fc          = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset.flag_zero",  bus.flag_zero,  1'b0);
        check("reset.flag_carry", bus.flag_carry, 1'b0);
        rst = 1'b0;

        // Directed decode points
        bus.insn = 8'h3C; #1;
        check("dec3C.xyzpq", {bus.insn_x, bus.insn_y, bus.insn_z, bus.insn_p, bus.insn_q},
              {2'd0, 3'd7, 3'd4, 2'd3, 1'b1});
        check("dec3C.is_inc_r", bus.is_inc_r, 1'b1);
        bus.insn = 8'h06; #1;
        check("dec06.is_ld_r_n", {bus.is_ld_r_n, bus.insn_y}, {1'b1, 3'd0});
        bus.insn = 8'hC3; #1;
        check("decC3.is_jp_nn", bus.is_jp_nn, 1'b1);
        bus.insn = 8'h00; #1;
        check("dec00.is_nop", bus.is_nop, 1'b1);

        // Full opcode sweep
        for (int i = 0; i < 256; i++) decode_check(i);

        // INC-style wrap and SUB borrow / equal
        alu_step("inc_wrap", 1, 8'hFF, 8'h01);
        alu_step("sub_borrow", 2, 8'h10, 8'h20);
        alu_step("sub_equal", 2, 8'h20, 8'h20);

        // Flag hold across NOPs, then logic op
        alu_step("sub_borrow2", 2, 8'h10, 8'h20);
        for (int i = 0; i < 3; i++) alu_step("nop_hold", 0, 8'h5A, 8'hA5);
        alu_step("and_zero", 3, 8'hF0, 8'h0F);

        // ADC/SBC with carry set beforehand (0x03/0x02 depending on build)
        alu_step("set_carry", 1, 8'hFF, 8'h01);
        alu_step("adc_chain", 6, 8'h01, 8'h01);
        alu_step("set_carry2", 1, 8'hFF, 8'h01);
        alu_step("adc_wrap", 6, 8'hFF, 8'h00);
        alu_step("adc_next", 6, 8'h00, 8'h00);
        alu_step("sbc_borrow", 7, 8'h00, 8'h00);
        alu_step("sbc_after", 7, 8'h05, 8'h02);

        // Reset mid-operation overrides the update, then the op lands
        rst = 1'b1;
        alu_step("rst_mid", 1, 8'hFF, 8'h01);
        rst = 1'b0;
        alu_step("rst_release", 1, 8'hFF, 8'h01);

        // Random traffic, including occasional reset
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            alu_step("rand", $urandom_range(0, 7), $urandom_range(0, 255),
                     $urandom_range(0, 255));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_alu_decode.md
# cpu_alu_decode

Combined datapath helper for the 8-bit Z80-style CPU core: a combinational instruction-field decoder plus an 8-bit ALU with registered zero/carry flags. The CPU state machine drives the current opcode and ALU operands from its own registers. It reads decoded fields during DECODE and the ALU result during EXECUTE, one cycle after operands are loaded.

## Interface
Parameters: none.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- insn  in  8  opcode byte under decode
- insn_x  out  2  insn[7:6]
- insn_y  out  3  insn[5:3] (register index, "r" table: B,C,D,E,H,L,(HL),A)
- insn_z  out  3  insn[2:0]
- insn_p  out  2  insn[5:4]
- insn_q  out  1  insn[3]
- is_nop  out  1  x=0, z=0, y=0
- is_inc_r  out  1  x=0, z=4
- is_ld_r_n  out  1  x=0, z=6
- is_jp_nn  out  1  x=3, z=3, y=0
- operand_a  in  8  ALU operand A
- operand_b  in  8  ALU operand B
- operator  in  3  ALU operation code
- result  out  8  combinational ALU result
- res_zero  out  1  combinational: result == 0
- res_carry  out  1  combinational carry/borrow of current operation
- flag_zero  out  1  registered zero flag
- flag_carry  out  1  registered carry flag

## Operation
- Decoder: purely combinational bit slicing and class detection. At most one class flag is high. Every other opcode leaves all class flags low.
- Operator codes:
  - 000 NOP: result = operand_a; carry 0
  - 001 ADD: a+b
  - 010 SUB: a−b
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 ADC: a+b+flag_carry
  - 111 SBC: a−b−flag_carry
- Arithmetic is 9-bit internally. result is bits [7:0].
  - ADD/ADC: res_carry = bit 8.
  - SUB/SBC: res_carry = borrow, i.e. a < b (+cin) unsigned.
  - AND/OR/XOR: res_carry = 0.
- Wrap-around: 0xFF+0x01 gives 0x00, zero=1, carry=1. 0x00−0x01 gives 0xFF, carry=1.
- Flag register: on a clock edge with rst=0 and operator≠NOP, flag_zero←res_zero and flag_carry←res_carry. With operator=NOP, the flags hold.

## Timing
- insn → decoder outputs: zero-cycle combinational.
- operand/operator → result, res_*: zero-cycle combinational, valid in the same cycle.
- Flags: one-cycle latency, visible the cycle after the operation is presented.
- Reset: flag_zero=0, flag_carry=0 on the first rising edge with rst=1. Reset overrides any concurrent flag update, including mid-sequence. Combinational outputs are unaffected by reset.
- ADC/SBC use the registered flag_carry from before the edge. Back-to-back ADCs therefore chain correctly, one per cycle.
- No handshake. The caller holds operands stable for the cycle it samples result.

## Configuration
- CPU_ALU_CARRY_IN_EN defined: codes 110/111 perform ADC/SBC as above.
- Not defined: 110 behaves exactly as ADD and 111 exactly as SUB, ignoring flag_carry. Flags still update.

## Structure
- Shared package/header (alu_defs): the 3-bit ALU_OP_* constants (NOP, ADD, SUB, AND, OR, XOR, ADC, SBC) and the register-index constants REG_B..REG_A (0..7, 6 = (HL)).
- One natural sub-module: cpu_insn_fields, the combinational decoder that produces x/y/z/p/q and the class flags. The ALU and flag register live in the top.

## Test plan
- Decode sweep: insn=0x3C → x=0, y=7, z=4, p=3, q=1, is_inc_r=1. insn=0x06 → is_ld_r_n=1, y=0. insn=0xC3 → is_jp_nn=1. insn=0x00 → is_nop=1. All 256 opcodes → at most one class flag high.
- INC wrap: a=0xFF, b=0x01, op=ADD → result=0x00, res_zero=1, res_carry=1; next cycle flag_zero=1 and flag_carry=1.
- SUB borrow: a=0x10, b=0x20 → result=0xF0, carry=1, zero=0. Then a=0x20, b=0x20 → result=0x00, zero=1, carry=0.
- Flag hold and logic: after carry=1, op=NOP for 3 cycles → flags unchanged. Then a=0xF0, b=0x0F, AND → result=0x00, zero=1, carry=0.
- ADC chain with macro defined: carry=1, a=0x01, b=0x01, ADC → 0x03. Without the macro → 0x02.
- Reset mid-op: with rst=1 and an ADD of 0xFF+0x01 presented → flags read 0 after the edge. With rst=0 on the next edge → flags become 1/1.
